// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type used by the
// decoder/mux slice.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_ERR1 = 2'd1,
        D_ERR2 = 2'd2
    } dflt_state_t;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped space: two-cycle ERROR response to NONSEQ/SEQ,
// zero-wait OKAY to IDLE/BUSY, plus a saturating count of rejected transfers.
module ahb_default_slave
    import ahb_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 sel,
    input  logic [1:0]           htrans,
    input  logic                 hready,
    output logic                 hreadyout,
    output logic                 hresp,
    output logic [CNT_WIDTH-1:0] err_count
);

    dflt_state_t          r_state;
    dflt_state_t          w_next;
    logic                 w_accept;
    logic [CNT_WIDTH-1:0] r_err_count;

    assign w_accept = hready && sel &&
                      ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= D_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        case (r_state)
            D_IDLE: begin
                if (w_accept) w_next = D_ERR1;
            end
            D_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                w_next    = D_ERR2;
            end
            D_ERR2: begin
                hresp  = HRESP_ERROR;
                // A pipelined unmapped transfer restarts the ERROR pair directly.
                w_next = w_accept ? D_ERR1 : D_IDLE;
            end
            default: begin
                w_next = D_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err_count <= '0;
        end else if (w_accept && (r_err_count != {CNT_WIDTH{1'b1}})) begin
            r_err_count <= r_err_count + CNT_WIDTH'(1);
        end
    end

    assign err_count = r_err_count;

endmodule

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite interconnect slice: address decoder, registered data-phase owner,
// response/read-data mux and a built-in ERROR default slave.
module ahb_decoder_mux
    import ahb_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    SLAVE_NUM    = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h4000_0000,
    parameter int                    REGION_SHIFT = 16,
    parameter int                    CNT_WIDTH    = 16,
    localparam int                   DSEL_W       = $clog2(SLAVE_NUM + 1)
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [ADDR_WIDTH-1:0]           haddr,
    input  logic [1:0]                      htrans,
    output logic [SLAVE_NUM:0]              hsel,
    input  logic [SLAVE_NUM-1:0]            slv_hreadyout,
    input  logic [SLAVE_NUM-1:0]            slv_hresp,
    input  logic [SLAVE_NUM*DATA_WIDTH-1:0] slv_hrdata,
    output logic                            hready,
    output logic                            hresp,
    output logic [DATA_WIDTH-1:0]           hrdata,
    output logic [DSEL_W-1:0]               data_sel,
    output logic [CNT_WIDTH-1:0]            err_count
);

    localparam int OFF_W = ADDR_WIDTH - REGION_SHIFT;

    logic [OFF_W-1:0]      w_off;
    logic [DSEL_W-1:0]     w_hsel_idx;
    logic [SLAVE_NUM:0]    w_hsel;
    logic [DSEL_W-1:0]     r_data_sel;
    logic                  w_hready;
    logic                  w_hresp;
    logic [DATA_WIDTH-1:0] w_hrdata;
    logic                  w_def_ready;
    logic                  w_def_resp;
    logic                  w_unused_addr;

    // Offset bits below the region size play no part in slave selection.
    assign w_unused_addr = ^haddr[REGION_SHIFT-1:0];

    // Unsigned subtraction: addresses below BASE_ADDR wrap to a large offset.
    assign w_off = haddr[ADDR_WIDTH-1:REGION_SHIFT] - BASE_ADDR[ADDR_WIDTH-1:REGION_SHIFT];

    always_comb begin
        w_hsel_idx = DSEL_W'(SLAVE_NUM);
        if (w_off < OFF_W'(SLAVE_NUM)) begin
            w_hsel_idx = DSEL_W'(w_off);
        end
        w_hsel = '0;
        for (int i = 0; i <= SLAVE_NUM; i++) begin
            w_hsel[i] = (w_hsel_idx == DSEL_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_data_sel <= DSEL_W'(SLAVE_NUM);
        end else if (w_hready) begin
            r_data_sel <= w_hsel_idx;
        end
    end

    always_comb begin
        w_hready = w_def_ready;
        w_hresp  = w_def_resp;
        w_hrdata = '0;
        for (int i = 0; i < SLAVE_NUM; i++) begin
            if (r_data_sel == DSEL_W'(i)) begin
                w_hready = slv_hreadyout[i];
                w_hresp  = slv_hresp[i];
                w_hrdata = slv_hrdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    ahb_default_slave #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_default_slave (
        .clk       (clk),
        .rstn      (rstn),
        .sel       (w_hsel[SLAVE_NUM]),
        .htrans    (htrans),
        .hready    (w_hready),
        .hreadyout (w_def_ready),
        .hresp     (w_def_resp),
        .err_count (err_count)
    );

    assign hsel     = w_hsel;
    assign hready   = w_hready;
    assign hresp    = w_hresp;
    assign hrdata   = w_hrdata;
    assign data_sel = r_data_sel;

endmodule

// File: doc/ahb_decoder_mux.md
Name: ahb_decoder_mux

Overview:
- Parametrised AHB-Lite interconnect slice: address-phase decoder, data-phase response multiplexer and built-in default slave in one block.
- Generalises the fixed-width decoder bundle (addr/selx/master_ready/multip_sel) to N slaves with configurable address map.
- Adds a registered data-phase select and an ERROR-responding default slave.
- Sits between the single AHB master and the slave devices.

Parameters:
- ADDR_WIDTH, 32, haddr width.
- DATA_WIDTH, 32, hrdata width.
- SLAVE_NUM, 4, number of real slaves (1..15).
- BASE_ADDR, 32'h4000_0000, base of slave 0; must be aligned to 2**REGION_SHIFT.
- REGION_SHIFT, 16, log2 of each slave's region size; slave i owns BASE_ADDR + i*2**REGION_SHIFT.
- CNT_WIDTH, 16, width of the unmapped-access counter.

Ports:
- clk  in  1  bus clock
- rstn  in  1  reset, asynchronous, active-low
- haddr  in  ADDR_WIDTH  master address
- htrans  in  2  master transfer type
- hsel  out  SLAVE_NUM+1  one-hot address-phase select; bit SLAVE_NUM = default slave
- slv_hreadyout  in  SLAVE_NUM  per-slave HREADYOUT
- slv_hresp  in  SLAVE_NUM  per-slave HRESP
- slv_hrdata  in  SLAVE_NUM*DATA_WIDTH  per-slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
- hready  out  1  muxed ready to master and all slaves (master_ready)
- hresp  out  1  muxed response
- hrdata  out  DATA_WIDTH  muxed read data
- data_sel  out  $clog2(SLAVE_NUM+1)  index of data-phase owner (multip_sel)
- err_count  out  CNT_WIDTH  saturating count of unmapped NONSEQ/SEQ transfers

Behaviour:
- Decode is combinational, independent of htrans.
  - off = haddr[ADDR_WIDTH-1:REGION_SHIFT] - BASE_ADDR[ADDR_WIDTH-1:REGION_SHIFT], unsigned.
  - If off < SLAVE_NUM, then hsel[off] = 1; otherwise hsel[SLAVE_NUM] = 1.
  - Exactly one hsel bit is high at all times, including during reset.
- data_sel register:
  - Loads the encoded hsel index when hready = 1.
  - Holds while hready = 0.
  - Reset value SLAVE_NUM (default slave).
- Mux: hready, hresp and hrdata are taken from slave data_sel.
  - When data_sel = SLAVE_NUM: hrdata = 0, and hready/hresp come from the default slave.
  - Output latency: combinational from slave inputs.
- Default slave FSM, states D_IDLE, D_ERR1, D_ERR2:
  - Reset: D_IDLE, driving hreadyout = 1, hresp = 0.
  - Accept condition: hready = 1 and hsel[SLAVE_NUM] = 1 and htrans[1] = 1 (NONSEQ/SEQ).
  - D_IDLE: on accept, go to D_ERR1; otherwise stay. IDLE/BUSY to unmapped space gets zero-wait OKAY.
  - D_ERR1: drives hreadyout = 0, hresp = 1; always goes to D_ERR2.
  - D_ERR2: drives hreadyout = 1, hresp = 1. On accept (pipelined back-to-back unmapped transfer) go to D_ERR1; otherwise go to D_IDLE.
- err_count:
  - Increments by 1 on each accept into the default slave.
  - Saturates at all-ones; no wrap.
  - Reset value 0.
- Reset values after rstn low:
  - hready = 1, hresp = 0, hrdata = 0, data_sel = SLAVE_NUM, err_count = 0.
  - hsel follows haddr.
- Reset mid-transfer: asynchronous, immediately forces the above values; an in-progress ERROR sequence is abandoned.
- Slave wait states: a slave holding hreadyout = 0 stalls data_sel and the default-slave FSM. A new address is not decoded into data_sel until hready = 1.
- Addresses below BASE_ADDR wrap to a large off and go to the default slave. Slave regions never alias.

Decomposition:
- Package ahb_pkg:
  - htrans encodings IDLE/BUSY/NONSEQ/SEQ.
  - HRESP OKAY/ERROR constants.
  - Default-slave state typedef.
- Sub-module ahb_default_slave:
  - Contains the FSM and err_count.
  - Inputs: clk, rstn, sel, htrans, hready.
  - Outputs: hreadyout, hresp, err_count.
- The top level holds the decoder, the data_sel register and the mux.

Test Plan:
- Reset then release with idle bus -> hready = 1, hresp = 0, hrdata = 0, data_sel = 4, err_count = 0.
- NONSEQ read at 0x4002_0010, slave 2 returns hreadyout = 1 with hrdata = 0xA5A5_0002 -> hsel = 5'b00100 in the address phase; next cycle data_sel = 2, hrdata = 0xA5A5_0002.
- Slave 1 inserts 3 wait states while the next address points at slave 3 -> data_sel stays 1 for 4 cycles, then becomes 3; hready low exactly 3 cycles.
- NONSEQ to 0x5000_0000 -> hsel = 5'b10000, then hready 0/hresp 1, then hready 1/hresp 1; err_count = 1.
- Back-to-back NONSEQ, SEQ to unmapped space, then IDLE -> two full ERROR pairs; err_count = 2; IDLE to unmapped space gives OKAY with no increment.
- CNT_WIDTH = 2, 5 unmapped transfers -> err_count saturates at 3; rstn asserted during D_ERR1 -> hready = 1, hresp = 0 immediately.
